// File: rtl/dq_dispatch_queue.sv
// dq_dispatch_queue: first-word fall-through dispatch FIFO for DQ-format ops with registered stall and sticky overflow.
// Optional DQ_DISPATCH_STALL_COUNT_EN adds a saturating stall-cycle counter output.
module dq_dispatch_queue #(
    parameter int regWidth = 5,
    parameter int immWidth = 12,
    parameter int depth    = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [regWidth-1:0]      reg1_i,
    input  logic [regWidth-1:0]      reg2_i,
    input  logic [1:0]               reg1Use_i,
    input  logic [1:0]               reg2Use_i,
    input  logic [immWidth-1:0]      imm_i,
    input  logic                     immFormat_i,
    input  logic                     bit_i,
    input  logic [2:0]               functionalUnitCode_i,
    output logic                     stall_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [regWidth-1:0]      reg1_o,
    output logic [regWidth-1:0]      reg2_o,
    output logic [1:0]               reg1Use_o,
    output logic [1:0]               reg2Use_o,
    output logic                     bit_o,
    output logic [2:0]               functionalUnitCode_o,
    output logic [63:0]              imm_o,
    output logic [$clog2(depth):0]   count_o,
`ifdef DQ_DISPATCH_STALL_COUNT_EN
    output logic [15:0]              stallCount_o,
`endif
    output logic                     overflow_o
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    typedef struct packed {
        logic [regWidth-1:0] reg1;
        logic [regWidth-1:0] reg2;
        logic [1:0]          reg1Use;
        logic [1:0]          reg2Use;
        logic [immWidth-1:0] imm;
        logic                immFormat;
        logic                dqBit;
        logic [2:0]          functionalUnitCode;
    } entry_t;

    entry_t          mem [depth];
    entry_t          head;
    logic [aw-1:0]   rd_ptr, wr_ptr, head_idx;
    logic [cw-1:0]   count, count_nxt;
    logic            full, push, pop;

    assign valid_o   = count != '0;
    assign full      = count == cw'(depth);
    assign pop       = valid_o & ready_i;
    assign push      = enable_i & (~full | pop);
    assign count_nxt = count + cw'(push) - cw'(pop);
    assign count_o   = count;

    // When empty, point at the last popped slot so head fields hold their values
    assign head_idx = valid_o ? rd_ptr : rd_ptr - aw'(1);
    assign head     = mem[head_idx];

    assign reg1_o               = head.reg1;
    assign reg2_o               = head.reg2;
    assign reg1Use_o            = head.reg1Use;
    assign reg2Use_o            = head.reg2Use;
    assign bit_o                = head.dqBit;
    assign functionalUnitCode_o = head.functionalUnitCode;
    assign imm_o = {{(64-immWidth){head.immFormat & head.imm[immWidth-1]}}, head.imm};

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            stall_o    <= 1'b0;
            overflow_o <= 1'b0;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else begin
            count   <= count_nxt;
            stall_o <= count_nxt >= cw'(depth - 1);
            if (pop) rd_ptr <= rd_ptr + aw'(1);
            if (push) begin
                mem[wr_ptr] <= '{reg1_i, reg2_i, reg1Use_i, reg2Use_i, imm_i, immFormat_i, bit_i,
                                 functionalUnitCode_i};
                wr_ptr      <= wr_ptr + aw'(1);
            end
            if (enable_i && full && !pop) overflow_o <= 1'b1;
        end
    end

`ifdef DQ_DISPATCH_STALL_COUNT_EN
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) stallCount_o <= '0;
        else if (stall_o && stallCount_o != 16'hFFFF) stallCount_o <= stallCount_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dq_dispatch_queue.sv
// tb_dq_dispatch_queue: randomized bench for dq_dispatch_queue against a queue-based reference model.
module tb_dq_dispatch_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [1:0]  u1;
        logic [1:0]  u2;
        logic [11:0] imm;
        logic        fmt;
        logic        b;
        logic [2:0]  fu;
    } ent_t;

    logic        clock_i = 1'b0, reset_i = 1'b0, enable_i = 1'b0, ready_i = 1'b0;
    logic [4:0]  reg1_i = '0, reg2_i = '0, reg1_o, reg2_o;
    logic [1:0]  reg1Use_i = '0, reg2Use_i = '0, reg1Use_o, reg2Use_o;
    logic [11:0] imm_i = '0;
    logic        immFormat_i = 1'b0, bit_i = 1'b0, bit_o, stall_o, valid_o, overflow_o;
    logic [2:0]  functionalUnitCode_i = '0, functionalUnitCode_o;
    logic [63:0] imm_o;
    logic [2:0]  count_o;
`ifdef DQ_DISPATCH_STALL_COUNT_EN
    logic [15:0] stallCount_o;
`endif

    int   checks = 0, errors = 0;
    ent_t q[$];
    ent_t last, cur_in;
    logic m_ovf;

    dq_dispatch_queue #(.regWidth(5), .immWidth(12), .depth(DEPTH)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .reg1Use_i(reg1Use_i), .reg2Use_i(reg2Use_i),
        .imm_i(imm_i), .immFormat_i(immFormat_i), .bit_i(bit_i),
        .functionalUnitCode_i(functionalUnitCode_i), .stall_o(stall_o), .valid_o(valid_o),
        .ready_i(ready_i), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg1Use_o(reg1Use_o),
        .reg2Use_o(reg2Use_o), .bit_o(bit_o), .functionalUnitCode_o(functionalUnitCode_o),
        .imm_o(imm_o), .count_o(count_o),
`ifdef DQ_DISPATCH_STALL_COUNT_EN
        .stallCount_o(stallCount_o),
`endif
        .overflow_o(overflow_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic ent_t rand_ent();
        logic [31:0] r = $urandom;
        return r[30:0];
    endfunction

    function automatic logic [63:0] ext(input ent_t e);
        longint v = e.fmt ? longint'($signed(e.imm)) : longint'(e.imm);
        return v;
    endfunction

    function automatic logic [87:0] exp_vec();
        ent_t h = (q.size() != 0) ? q[0] : last;
        return {q.size() != 0, 3'(q.size()), q.size() >= DEPTH - 1, m_ovf,
                h.r1, h.r2, h.u1, h.u2, h.b, h.fu, ext(h)};
    endfunction

    function automatic logic [87:0] got_vec();
        return {valid_o, count_o, stall_o, overflow_o, reg1_o, reg2_o, reg1Use_o, reg2Use_o,
                bit_o, functionalUnitCode_o, imm_o};
    endfunction

    task automatic set_in(input logic en, input ent_t e, input logic rdy);
        enable_i = en;
        ready_i  = rdy;
        cur_in   = e;
        {reg1_i, reg2_i, reg1Use_i, reg2Use_i, imm_i, immFormat_i, bit_i, functionalUnitCode_i} = e;
    endtask

    // Advance one clock edge, applying the same edge to the reference queue
    task automatic do_cycle();
        int  sz = q.size();
        bit  p, o;
        o = (sz != 0) && ready_i;
        p = enable_i && (sz < DEPTH || o);
        if (enable_i && sz == DEPTH && !o) m_ovf = 1'b1;
        if (o) void'(q.pop_front());
        if (p) q.push_back(cur_in);
        @(posedge clock_i);
        #1;
        if (q.size() != 0) last = q[0];
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        set_in(1'b0, '0, 1'b0);
        #2;
        reset_i = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        last  = '0;
    endtask

    task automatic test_reset();
        @(posedge clock_i);
        #1;
        do_reset();
        checks++;
        if ({valid_o, count_o, stall_o, overflow_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000000", {valid_o, count_o, stall_o, overflow_o});
        end
        checks++;
        if ({reg1_o, reg2_o, imm_o} !== 74'b0) begin
            errors++;
            $display("FAIL reset_head got=%h exp=0", {reg1_o, reg2_o, imm_o});
        end
    endtask

    task automatic test_imm_ext();
        for (int f = 1; f >= 0; f--) begin
            do_reset();
            set_in(1'b1, '{5'd3, 5'd7, 2'd1, 2'd2, 12'hFFF, f[0], 1'b1, 3'd5}, 1'b0);
            do_cycle();
            set_in(1'b0, '0, 1'b0);
            checks++;
            if ({valid_o, count_o} !== 4'b1_001) begin
                errors++;
                $display("FAIL imm_ext_valid fmt=%0d got=%b exp=1001", f, {valid_o, count_o});
            end
            checks++;
            if (imm_o !== (f == 1 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_0FFF)) begin
                errors++;
                $display("FAIL imm_ext_value fmt=%0d got=%h", f, imm_o);
            end
            checks++;
            if ({reg1_o, reg2_o, functionalUnitCode_o} !== {5'd3, 5'd7, 3'd5}) begin
                errors++;
                $display("FAIL imm_ext_regs got=%0d,%0d,%0d exp=3,7,5", reg1_o, reg2_o, functionalUnitCode_o);
            end
        end
    endtask

    task automatic test_fill_overflow();
        ent_t first;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            ent_t e = rand_ent();
            if (i == 1) first = e;
            set_in(1'b1, e, 1'b0);
            do_cycle();
            checks++;
            if (count_o !== 3'(i > 4 ? 4 : i) || stall_o !== (i >= 3) || overflow_o !== (i == 5)) begin
                errors++;
                $display("FAIL fill push%0d got cnt=%0d stall=%b ovf=%b exp cnt=%0d stall=%b ovf=%b",
                         i, count_o, stall_o, overflow_o, i > 4 ? 4 : i, i >= 3, i == 5);
            end
        end
        checks++;
        if (reg1_o !== first.r1 || imm_o !== ext(first)) begin
            errors++;
            $display("FAIL fill_head got=%h/%h exp=%h/%h", reg1_o, imm_o, first.r1, ext(first));
        end
    endtask

    task automatic test_wrap_order();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, rand_ent(), 1'b1);
            do_cycle();
            checks++;
            if (got_vec() !== exp_vec() || count_o !== 3'd4) begin
                errors++;
                $display("FAIL wrap op%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, rand_ent(), 1'b1);
            do_cycle();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain step%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 99) < 60, rand_ent(), $urandom_range(0, 99) < 45);
            do_cycle();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, rand_ent(), 1'b0);
            do_cycle();
        end
        checks++;
        if (count_o !== 3'd3 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL async_pre got cnt=%0d stall=%b exp cnt=3 stall=1", count_o, stall_o);
        end
        #2;
        reset_i = 1'b0;
        #1;
        checks++;
        if ({valid_o, count_o, stall_o, overflow_o} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=000000", {valid_o, count_o, stall_o, overflow_o});
        end
        #2;
        reset_i = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        last  = '0;
        set_in(1'b1, rand_ent(), 1'b0);
        do_cycle();
        checks++;
        if (got_vec() !== exp_vec() || count_o !== 3'd1) begin
            errors++;
            $display("FAIL first_push_after_reset got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    initial begin
        m_ovf = 1'b0;
        last  = '0;
        test_reset();
        test_imm_ext();
        test_fill_overflow();
        test_wrap_order();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
